// File: rtl/sr_serial.sv
// sr_serial: multi-cycle right shifter, logical or arithmetic, under a Start/Done handshake.
// Build option: define SR_SERIAL_DUAL_STEP_EN to shift two positions per step while counter >= 2.
`timescale 1ns/1ps
module sr_serial #(
  parameter int n = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 Start,
  input  logic [n-1:0]         In,
  input  logic [$clog2(n)-1:0] Shamt,
  input  logic                 Arith,
  output logic                 Busy,
  output logic                 Done,
  output logic [n-1:0]         Out
);
  localparam int CW = $clog2(n);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [n-1:0]  data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          arith_q, arith_d;
  logic          fill;

  // Sign fill is taken from the current MSB so repeated steps keep propagating it.
  assign fill = arith_q & data_q[n-1];

  always_comb begin
    // NOTE: every variable gets a hold value first so no path through the case infers a latch.
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    arith_d = arith_q;
    case (state_q)
      IDLE, DONE: begin
        if (Start) begin
          data_d  = In;
          cnt_d   = Shamt;
          arith_d = Arith;
          state_d = (Shamt != '0) ? SHIFT : DONE;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
`ifdef SR_SERIAL_DUAL_STEP_EN
        if (cnt_q >= CW'(2)) begin
          data_d = {{2{fill}}, data_q[n-1:2]};
          cnt_d  = cnt_q - CW'(2);
        end else begin
          data_d = {fill, data_q[n-1:1]};
          cnt_d  = cnt_q - CW'(1);
        end
`else
        data_d = {fill, data_q[n-1:1]};
        cnt_d  = cnt_q - CW'(1);
`endif
        if (cnt_d == '0) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      arith_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      arith_q <= arith_d;
    end
  end

  assign Busy = (state_q == SHIFT);
  assign Done = (state_q == DONE);
  assign Out  = data_q;

endmodule

// File: tb/tb_sr_serial.sv
// Self-checking bench for sr_serial: directed plan items plus randomized operations
// compared against a shift/latency reference model.
`timescale 1ns/1ps
module tb_sr_serial;
  localparam int N  = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          Start;
  logic [N-1:0]  In;
  logic [CW-1:0] Shamt;
  logic          Arith;
  logic          Busy;
  logic          Done;
  logic [N-1:0]  Out;

  int n_checks = 0;
  int n_pass   = 0;

  sr_serial #(.n(N)) dut (
    .clk   (clk),
    .reset (reset),
    .Start (Start),
    .In    (In),
    .Shamt (Shamt),
    .Arith (Arith),
    .Busy  (Busy),
    .Done  (Done),
    .Out   (Out)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference result: plain logical / arithmetic right shift of the operand.
  function automatic logic [N-1:0] ref_shift(input logic [N-1:0] v, input int k, input logic ar);
    logic signed [N-1:0] s;
    s = v;
    if (ar) return s >>> k;
    return v >> k;
  endfunction

  // Number of SHIFT edges before DONE for a shift of k.
  function automatic int lat_of(input int k);
`ifdef SR_SERIAL_DUAL_STEP_EN
    return (k + 1) / 2;
`else
    return k;
`endif
  endfunction

  // Issues one operation and checks Busy/Done on every cycle up to and including the Done cycle.
  // Returns while Done is high, so a following call starts back-to-back from DONE.
  task automatic run_op(input string name, input logic [N-1:0] v, input int k, input logic ar,
                        input bit collide, input bit noise);
    int lat;
    lat   = lat_of(k);
    Start = 1'b1;
    In    = v;
    Shamt = CW'(k);
    Arith = ar;
    tick;
    Start = 1'b0;
    for (int j = 0; j <= lat; j++) begin
      if (j > 0) tick;
      check($sformatf("%s busy@E%0d", name, j), Busy, (k != 0) && (j < lat));
      check($sformatf("%s done@E%0d", name, j), Done, j == lat);
      if (j < lat) begin
        if (noise) begin
          In    = N'($urandom);
          Shamt = CW'($urandom_range(N - 1));
          Arith = 1'($urandom_range(1));
          Start = 1'($urandom_range(1));
        end
        if (collide) begin
          Start = (j == 0);
          if (j == 0) In = 16'hFFFF;
        end
      end
    end
    Start = 1'b0;
    check($sformatf("%s out", name), Out, ref_shift(v, k, ar));
  endtask

  task automatic idle(input string name, input int cycles, input logic [N-1:0] exp_out);
    repeat (cycles) tick;
    check($sformatf("%s idle busy", name), Busy, 1'b0);
    check($sformatf("%s idle done", name), Done, 1'b0);
    check($sformatf("%s idle out", name), Out, exp_out);
  endtask

  initial begin
    logic [N-1:0] last;
    reset = 1'b0;
    Start = 1'b0;
    In    = '0;
    Shamt = '0;
    Arith = 1'b0;

    // Reset state, with Start held high to show it is ignored while in reset.
    tick;
    Start = 1'b1;
    In    = 16'hBEEF;
    Shamt = 4'd3;
    tick;
    tick;
    Start = 1'b0;
    check("reset busy", Busy, 1'b0);
    check("reset done", Done, 1'b0);
    check("reset out", Out, 16'h0000);
    reset = 1'b1;
    idle("post reset", 1, 16'h0000);

    // Logical shift, then result held through idle.
    run_op("lsr", 16'hF000, 4, 1'b0, 1'b0, 1'b0);
    check("lsr literal", Out, 16'h0F00);
    idle("lsr hold", 3, 16'h0F00);

    // Arithmetic shift by the maximum amount.
    run_op("asr", 16'h8001, 15, 1'b1, 1'b0, 1'b0);
    check("asr literal", Out, 16'hFFFF);
    idle("asr", 1, 16'hFFFF);

    // Zero shift, then byte-to-word conversion back-to-back from DONE.
    run_op("zero", 16'h1234, 0, 1'b0, 1'b0, 1'b0);
    check("zero literal", Out, 16'h1234);
    run_op("word", 16'h0104, 2, 1'b0, 1'b0, 1'b0);
    check("word literal", Out, 16'h0041);
    idle("word", 1, 16'h0041);

    // Start during SHIFT is ignored; a Start during Done is accepted.
    run_op("coll", 16'hAAAA, 3, 1'b0, 1'b1, 1'b0);
    check("coll literal", Out, 16'h1555);
    run_op("b2b", 16'h0010, 1, 1'b0, 1'b0, 1'b0);
    check("b2b literal", Out, 16'h0008);
    idle("b2b", 1, 16'h0008);

    // Reset asserted just after E2 of a 10-step operation.
    Start = 1'b1;
    In    = 16'h7F3C;
    Shamt = 4'd10;
    Arith = 1'b1;
    tick;
    Start = 1'b0;
    tick;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst busy", Busy, 1'b0);
    check("midrst done", Done, 1'b0);
    check("midrst out", Out, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("midrst no done %0d", i), Done, 1'b0);
    end
    reset = 1'b1;
    idle("midrst release", 1, 16'h0000);
    run_op("after rst", 16'hC3A5, 5, 1'b1, 1'b0, 1'b0);
    idle("after rst", 1, ref_shift(16'hC3A5, 5, 1'b1));

    // Randomized operations with input noise while shifting and random gaps.
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] v;
      int           k;
      logic         ar;
      int           gap;
      v   = N'($urandom);
      k   = $urandom_range(N - 1);
      ar  = 1'($urandom_range(1));
      gap = $urandom_range(2);
      run_op($sformatf("rnd%0d", i), v, k, ar, 1'b0, 1'b1);
      last = ref_shift(v, k, ar);
      if (gap != 0) idle($sformatf("rnd%0d", i), gap, last);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
